// File: rtl/cart_001.sv
// cart_001 -- NES MMC1 (mapper 001) cartridge: serial 5-bit register port, PRG/CHR banking, mirroring, PRG RAM, optional CHR RAM.
// Latency: register updates land on the clk_cpu edge of the completing write; all reads are zero-latency combinational.
// Backpressure: none; the cartridge follows the CPU/PPU bus unconditionally, and a write in the cycle right after an accepted write is dropped.
//
// Ports:
//   clk_cpu, rst                    sole clock (one edge per CPU bus cycle), synchronous active-high reset
//   m2, cpu_rw, romsel, cpu_addr    CPU bus qualifiers and address A[14:0] (romsel low = $8000-$FFFF)
//   cpu_data_i / cpu_data_o         CPU write data / PRG ROM or PRG RAM read data
//   ppu_addr, ppu_rd, ppu_wr        PPU bus address and strobes (ppu_rd is advisory only)
//   ppu_data_i / ppu_data_o         CHR RAM write data / CHR read data
//   ciram_ce, ciram_a10             console nametable RAM enable and page select
//   irq                             tied low
`ifndef ROM_PATH
`define ROM_PATH "./"
`endif

module cart_001 #(
  parameter     PRG_FILE      = {`ROM_PATH, "PRG.mem"},
  parameter     CHR_FILE      = {`ROM_PATH, "CHR.mem"},
  parameter int PRG_ROM_DEPTH = 18,
  parameter int CHR_ROM_DEPTH = 17,
  parameter int PRG_RAM_EN    = 1,
  parameter int CHR_RAM       = 0
) (
  input  logic        clk_cpu,
  input  logic        rst,
  input  logic        m2,
  input  logic [14:0] cpu_addr,
  input  logic [7:0]  cpu_data_i,
  output logic [7:0]  cpu_data_o,
  input  logic        cpu_rw,
  input  logic        romsel,
  output logic        ciram_ce,
  output logic        ciram_a10,
  input  logic [13:0] ppu_addr,
  input  logic [7:0]  ppu_data_i,
  output logic [7:0]  ppu_data_o,
  input  logic        ppu_rd,
  input  logic        ppu_wr,
  output logic        irq
);

  // Image file names are consumed by the memory preload flow, not by this logic.
  localparam int unused_file_bits = $bits(PRG_FILE) + $bits(CHR_FILE);

  localparam logic [4:0] SHIFT_EMPTY = 5'b10000;

  // Mapper state
  logic [4:0] shift_q, shift_d;
  logic       last_w_q, last_w_d;
  logic [4:0] ctrl_q, ctrl_d;
  logic [4:0] chr0_q, chr0_d;
  logic [4:0] chr1_q, chr1_d;
  logic [4:0] prg_q, prg_d;

  // Memories
  logic [7:0] prg_rom [0:(1 << PRG_ROM_DEPTH) - 1];
  logic [7:0] chr_rom [0:(1 << CHR_ROM_DEPTH) - 1];
  logic [7:0] prg_ram [0:8191];
  logic [7:0] chr_ram [0:8191];

  logic       wr_evt;
  logic       wr_acc;
  logic [4:0] shift_post;

  assign wr_evt     = m2 && !cpu_rw && !romsel;
  // Read-modify-write instructions issue two back-to-back writes; only the first counts.
  assign wr_acc     = wr_evt && !last_w_q;
  assign shift_post = {cpu_data_i[0], shift_q[4:1]};

  always_comb begin
    shift_d  = shift_q;
    ctrl_d   = ctrl_q;
    chr0_d   = chr0_q;
    chr1_d   = chr1_q;
    prg_d    = prg_q;
    // An ignored back-to-back write keeps the flag set; only a non-write cycle clears it.
    last_w_d = wr_evt;
    if (wr_acc) begin
      if (cpu_data_i[7]) begin
        shift_d = SHIFT_EMPTY;
        ctrl_d  = ctrl_q | 5'b01100;
      end else if (shift_q[0]) begin
        // Marker reached bit 0: this is the fifth bit, commit the assembled value.
        unique case (cpu_addr[14:13])
          2'b00:   ctrl_d = shift_post;
          2'b01:   chr0_d = shift_post;
          2'b10:   chr1_d = shift_post;
          default: prg_d  = shift_post;
        endcase
        shift_d = SHIFT_EMPTY;
      end else begin
        shift_d = shift_post;
      end
    end
  end

  always_ff @(posedge clk_cpu) begin
    if (rst) begin
      shift_q  <= SHIFT_EMPTY;
      last_w_q <= 1'b0;
      ctrl_q   <= 5'b01100;
      chr0_q   <= 5'd0;
      chr1_q   <= 5'd0;
      prg_q    <= 5'd0;
    end else begin
      shift_q  <= shift_d;
      last_w_q <= last_w_d;
      ctrl_q   <= ctrl_d;
      chr0_q   <= chr0_d;
      chr1_q   <= chr1_d;
      prg_q    <= prg_d;
    end
  end

  // Nametable mirroring
  always_comb begin
    unique case (ctrl_q[1:0])
      2'd0:    ciram_a10 = 1'b0;
      2'd1:    ciram_a10 = 1'b1;
      2'd2:    ciram_a10 = ppu_addr[10];
      default: ciram_a10 = ppu_addr[11];
    endcase
  end

  assign ciram_ce = ppu_addr[13];
  assign irq      = 1'b0;

  // PRG banking: 16 KB bank index from mode and A14
  logic [3:0]  prg_bank;
  logic [17:0] prg_full;

  always_comb begin
    unique case (ctrl_q[3:2])
      2'd0, 2'd1: prg_bank = {prg_q[3:1], cpu_addr[14]};
      2'd2:       prg_bank = cpu_addr[14] ? prg_q[3:0] : 4'h0;
      default:    prg_bank = cpu_addr[14] ? 4'hF : prg_q[3:0];
    endcase
  end

  // Truncation wraps oversize bank numbers, so 4'hF always lands on the last bank.
  assign prg_full = {prg_bank, cpu_addr[13:0]};

  // PRG RAM at $6000-$7FFF, gated off by prg[4]
  logic prg_ram_sel;

  assign prg_ram_sel = romsel && (cpu_addr[14:13] == 2'b11) && m2 &&
                       (PRG_RAM_EN != 0) && !prg_q[4];

  always_ff @(posedge clk_cpu) begin
    if (prg_ram_sel && !cpu_rw) begin
      prg_ram[cpu_addr[12:0]] <= cpu_data_i;
    end
  end

  always_comb begin
    cpu_data_o = 8'h00;
    if (!romsel) begin
      cpu_data_o = prg_rom[prg_full[PRG_ROM_DEPTH-1:0]];
    end else if (prg_ram_sel) begin
      cpu_data_o = prg_ram[cpu_addr[12:0]];
    end
  end

  // CHR banking: one 8 KB bank (chr0 even-aligned) or two independent 4 KB banks
  logic [16:0] chr_full;

  always_comb begin
    if (ctrl_q[4]) begin
      chr_full = {(ppu_addr[12] ? chr1_q : chr0_q), ppu_addr[11:0]};
    end else begin
      chr_full = {chr0_q[4:1], ppu_addr[12:0]};
    end
  end

  always_ff @(posedge clk_cpu) begin
    if ((CHR_RAM != 0) && ppu_wr && !ppu_addr[13]) begin
      chr_ram[chr_full[12:0]] <= ppu_data_i;
    end
  end

  assign ppu_data_o = (CHR_RAM != 0) ? chr_ram[chr_full[12:0]]
                                     : chr_rom[chr_full[CHR_ROM_DEPTH-1:0]];

  // Inputs with no function in this mapper
  logic unused_sig;
  assign unused_sig = ^{ppu_rd, cpu_data_i[6:1]};

endmodule

// File: tb/tb_cart_001.sv
module tb_cart_001;

  logic        clk_cpu;
  logic        rst;
  logic        m2;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_data_i;
  logic [7:0]  cpu_data_o;
  logic        cpu_rw;
  logic        romsel;
  logic        ciram_ce;
  logic        ciram_a10;
  logic [13:0] ppu_addr;
  logic [7:0]  ppu_data_i;
  logic [7:0]  ppu_data_o;
  logic        ppu_rd;
  logic        ppu_wr;
  logic        irq;

  int vecs;
  int miscompares;

  cart_001 dut (
    .clk_cpu    (clk_cpu),
    .rst        (rst),
    .m2         (m2),
    .cpu_addr   (cpu_addr),
    .cpu_data_i (cpu_data_i),
    .cpu_data_o (cpu_data_o),
    .cpu_rw     (cpu_rw),
    .romsel     (romsel),
    .ciram_ce   (ciram_ce),
    .ciram_a10  (ciram_a10),
    .ppu_addr   (ppu_addr),
    .ppu_data_i (ppu_data_i),
    .ppu_data_o (ppu_data_o),
    .ppu_rd     (ppu_rd),
    .ppu_wr     (ppu_wr),
    .irq        (irq)
  );

  initial begin
    clk_cpu = 1'b0;
    forever #5 clk_cpu = ~clk_cpu;
  end

  // Memory image pattern: byte value depends on offset and on bank bits.
  function automatic logic [7:0] pat(input int a, input logic [7:0] salt);
    int t;
    t = a * 13 + (a >> 7) + (a >> 14) * 37;
    return t[7:0] ^ salt;
  endfunction

  function automatic logic [7:0] prg_exp(input int a);
    return pat(a, 8'h00);
  endfunction

  function automatic logic [7:0] chr_exp(input int a);
    return pat(a, 8'h5A);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [14:0] a, input logic [7:0] d, input logic rs);
    @(negedge clk_cpu);
    cpu_addr   = a;
    cpu_data_i = d;
    romsel     = rs;
    cpu_rw     = 1'b0;
    m2         = 1'b1;
    @(negedge clk_cpu);
    cpu_rw = 1'b1;
    romsel = 1'b1;
  endtask

  // Five serial writes, LSB first, separated by idle cycles.
  task automatic load(input logic [14:0] a, input logic [4:0] v);
    for (int i = 0; i < 5; i++) wr(a, {7'b0, v[i]}, 1'b0);
  endtask

  task automatic rd_cpu(input string tag, input logic [14:0] a, input logic rs, input logic [7:0] exp);
    cpu_rw   = 1'b1;
    cpu_addr = a;
    romsel   = rs;
    #1;
    chk(tag, cpu_data_o, exp);
  endtask

  task automatic rd_a10(input string tag, input logic [13:0] a, input logic exp);
    ppu_addr = a;
    #1;
    chk(tag, {7'b0, ciram_a10}, {7'b0, exp});
  endtask

  task automatic rd_chr(input string tag, input logic [13:0] a, input logic [7:0] exp);
    ppu_addr = a;
    #1;
    chk(tag, ppu_data_o, exp);
  endtask

  initial begin
    vecs        = 0;
    miscompares = 0;
    rst         = 1'b1;
    m2          = 1'b1;
    cpu_rw      = 1'b1;
    romsel      = 1'b1;
    cpu_addr    = 15'h0;
    cpu_data_i  = 8'h00;
    ppu_addr    = 14'h0;
    ppu_data_i  = 8'h00;
    ppu_rd      = 1'b0;
    ppu_wr      = 1'b0;

    for (int i = 0; i < (1 << 18); i++) dut.prg_rom[i] = prg_exp(i);
    for (int i = 0; i < (1 << 17); i++) dut.chr_rom[i] = chr_exp(i);

    repeat (2) @(negedge clk_cpu);
    rst = 1'b0;

    // Reset state: PRG mode 3, prg=0, one-screen page 0, CHR 8 KB bank 0
    rd_cpu("rst_hi_bank", 15'h4000, 1'b0, prg_exp(18'h3C000));
    rd_cpu("rst_lo_bank", 15'h0123, 1'b0, prg_exp(18'h00123));
    rd_a10("rst_a10", 14'h2400, 1'b0);
    chk("rst_ciram_ce", {7'b0, ciram_ce}, 8'h01);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    rd_chr("rst_chr", 14'h0010, chr_exp(17'h00010));

    // Control = 01110: vertical mirroring, PRG mode 3
    load(15'h0000, 5'b01110);
    rd_a10("ctl_vert_2400", 14'h2400, 1'b1);
    rd_a10("ctl_vert_2800", 14'h2800, 1'b0);

    // prg = 5
    load(15'h6000, 5'd5);
    rd_cpu("m3_lo", 15'h0123, 1'b0, prg_exp(18'h14123));
    rd_cpu("m3_hi_fixed", 15'h4000, 1'b0, prg_exp(18'h3C000));

    // PRG mode 2: low bank fixed to 0, high bank switchable
    load(15'h0000, 5'b01010);
    rd_cpu("m2_lo_fixed", 15'h0123, 1'b0, prg_exp(18'h00123));
    rd_cpu("m2_hi", 15'h4123, 1'b0, prg_exp(18'h14123));

    // PRG mode 0: 32 KB bank from prg[3:1] -> banks 4,5
    load(15'h0000, 5'b00010);
    rd_cpu("m0_lo", 15'h0123, 1'b0, prg_exp(18'h10123));
    rd_cpu("m0_hi", 15'h4123, 1'b0, prg_exp(18'h14123));

    // Back-to-back writes: second (bit 0) ignored; target control 00011
    @(negedge clk_cpu);
    cpu_addr = 15'h0000; cpu_data_i = 8'h01; romsel = 1'b0; cpu_rw = 1'b0; m2 = 1'b1;
    @(negedge clk_cpu);
    cpu_data_i = 8'h00;
    @(negedge clk_cpu);
    cpu_rw = 1'b1; romsel = 1'b1;
    wr(15'h0000, 8'h01, 1'b0);
    wr(15'h0000, 8'h00, 1'b0);
    wr(15'h0000, 8'h00, 1'b0);
    rd_a10("rmw_pending_2400", 14'h2400, 1'b1);
    rd_a10("rmw_pending_2800", 14'h2800, 1'b0);
    wr(15'h0000, 8'h00, 1'b0);
    rd_a10("rmw_horiz_2800", 14'h2800, 1'b1);
    rd_a10("rmw_horiz_2400", 14'h2400, 1'b0);
    rd_cpu("rmw_m0_lo", 15'h0123, 1'b0, prg_exp(18'h10123));

    // Bit-7 reset mid-sequence: control |= 01100 -> 01111
    wr(15'h0000, 8'h01, 1'b0);
    wr(15'h0000, 8'h01, 1'b0);
    wr(15'h0000, 8'h80, 1'b0);
    rd_cpu("b7_m3_hi", 15'h4000, 1'b0, prg_exp(18'h3C000));
    rd_cpu("b7_m3_lo", 15'h0123, 1'b0, prg_exp(18'h14123));
    rd_a10("b7_horiz", 14'h2800, 1'b1);

    // Fresh load after discard, then CHR 4 KB mode
    load(15'h0000, 5'b10010);
    rd_a10("fresh_vert", 14'h2400, 1'b1);
    load(15'h2000, 5'd3);
    load(15'h4000, 5'd7);
    rd_chr("chr4k_lo", 14'h0010, chr_exp(17'h03010));
    rd_chr("chr4k_hi", 14'h1010, chr_exp(17'h07010));

    // CHR 8 KB mode: chr0[4:1] = 1
    load(15'h0000, 5'b00010);
    rd_chr("chr8k", 14'h1234, chr_exp(17'h03234));

    // PRG RAM
    wr(15'h6000, 8'hA5, 1'b1);
    rd_cpu("ram_rd", 15'h6000, 1'b1, 8'hA5);
    rd_cpu("ram_undecoded", 15'h2000, 1'b1, 8'h00);
    load(15'h6000, 5'b10101);
    rd_cpu("ram_disabled", 15'h6000, 1'b1, 8'h00);
    wr(15'h6000, 8'h3C, 1'b1);
    load(15'h6000, 5'b00101);
    rd_cpu("ram_reenabled", 15'h6000, 1'b1, 8'hA5);

    // Reset concurrent with a completing write: reset wins
    for (int i = 0; i < 4; i++) wr(15'h0000, 8'h01, 1'b0);
    @(negedge clk_cpu);
    rst = 1'b1; cpu_addr = 15'h0000; cpu_data_i = 8'h01; romsel = 1'b0; cpu_rw = 1'b0; m2 = 1'b1;
    @(negedge clk_cpu);
    rst = 1'b0; cpu_rw = 1'b1; romsel = 1'b1;
    rd_a10("rstw_2800", 14'h2800, 1'b0);
    rd_a10("rstw_2400", 14'h2400, 1'b0);
    rd_cpu("rstw_lo", 15'h0123, 1'b0, prg_exp(18'h00123));
    rd_cpu("rstw_hi", 15'h4000, 1'b0, prg_exp(18'h3C000));
    load(15'h0000, 5'b00011);
    rd_a10("post_rst_load", 14'h2800, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, vectors %0d", vecs);
    $fatal(1, "timeout");
  end

endmodule
